uart_apb_sequencer: RTL
=======================

# uart_apb_sequencer

Bus-master sequencer that drives one `uart_binary` instance through its APB-style register port, turning a single byte-level request into the full setup/access/idle write sequence: baud divisor (addr 4), T/R mode (addr 2), then data (addr 0). It sits between a simple valid/ready requester (CPU shim or DMA) and the UART, replacing hand-sequenced bus cycles. It holds each access phase until the UART asserts `ready`, returns received bytes, and aborts stalled transfers with a timeout.

## Interface
- `TIMEOUT_CYCLES`, 4096: maximum cycles any access phase may wait for `uart_ready` before abort; minimum legal value 2.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle and able to accept.
- `req_dir` in 1: 0 = transmit (mode 1), 1 = receive (mode 2).
- `req_baud` in 16: baud divisor, zero-extended to 32 bits on the bus.
- `req_data` in 8: transmit byte; ignored when `req_dir`=1.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: received byte (rx) or 0x00 (tx); valid with `rsp_valid`.
- `rsp_err` out 1: transfer aborted by timeout; valid with `rsp_valid`.
- `uart_sel` out 1: UART select.
- `uart_enable` out 1: access-phase strobe.
- `uart_addr` out 10: word address [11:2].
- `uart_wdata` out 32: write data to the UART (`data_out` port).
- `uart_rdata` in 32: read data from the UART (`data_in` port).
- `uart_ready` in 1: UART access complete.

## Operation
- States: IDLE, BAUD_SETUP, BAUD_ACCESS, GAP1, MODE_SETUP, MODE_ACCESS, GAP2, DATA_SETUP, DATA_ACCESS, DONE.
- IDLE: `req_ready`=1; on `req_valid` capture dir/baud/data into internal registers, go to BAUD_SETUP.
- *_SETUP: `uart_sel`=1, `uart_enable`=0, addr/wdata driven; always exactly one cycle.
- *_ACCESS: `uart_sel`=1, `uart_enable`=1, addr/wdata held; leave on `uart_ready`=1.
- GAPn: `uart_sel`=0, `uart_enable`=0, addr=0, wdata=0; exactly one cycle.
- Address/data per phase: BAUD addr=4, wdata=captured baud (baud 0 written as 1); MODE addr=2, wdata=1 (tx) or 2 (rx); DATA addr=0, wdata={24'h0, byte} for tx, 0 for rx.
- DATA_ACCESS exit with ready: rx latches `uart_rdata[7:0]` into `rsp_data`; go to DONE.
- DONE: `rsp_valid`=1 for one cycle, bus idle, return to IDLE. `rsp_data`/`rsp_err` hold until next acceptance.
- Timeout: counter clears on entry to every ACCESS state, increments each cycle `uart_ready`=0; reaching `TIMEOUT_CYCLES` drops sel/enable next cycle, goes to DONE with `rsp_err`=1, `rsp_data`=0.
- `uart_ready` outside ACCESS states is ignored.
- Request inputs may change after acceptance with no effect on the transfer in flight.

## Timing
- Reset: all outputs 0 except `req_ready`=1; state IDLE; timeout counter 0; baud cache invalid.
- Reset asserted mid-transfer: bus signals drop to 0 asynchronously, no `rsp_valid` issued, in-flight request discarded.
- Accept on edge k (req_valid & req_ready). With `uart_ready` tied high: BAUD_SETUP k+1, BAUD_ACCESS k+2, GAP1 k+3, MODE_SETUP k+4, MODE_ACCESS k+5, GAP2 k+6, DATA_SETUP k+7, DATA_ACCESS k+8, `rsp_valid` k+9. Each ready-low cycle in an ACCESS state adds one cycle.
- `req_ready` low from k+1 through DONE; earliest next acceptance is the cycle after DONE.
- Timeout: with `uart_ready` stuck low, `rsp_valid`/`rsp_err` asserted `TIMEOUT_CYCLES`+1 cycles after entering the stalled ACCESS state.

## Configuration
- `UART_SEQ_BAUD_CACHE_EN` defined: sequencer keeps last successfully written baud (valid flag cleared by reset and by a timeout in BAUD_ACCESS); if the new request's effective baud matches, BAUD_SETUP/BAUD_ACCESS/GAP1 are skipped and IDLE goes directly to MODE_SETUP, giving `rsp_valid` at k+6 with ready high.
- Undefined: baud write issued on every request; no cache registers exist.

## Test plan
- Tx, baud 20, data 53, ready tied high -> bus writes (4,20),(2,1),(0,53) with single-cycle gaps; `rsp_valid` at k+9, `rsp_err`=0, `rsp_data`=0.
- Rx, baud 40, UART returns `data_in`=10 after 30 ready-low cycles in DATA_ACCESS -> writes (4,40),(2,2), access held 30 cycles; `rsp_data`=10 at k+39.
- `uart_ready` stuck low in MODE_ACCESS, `TIMEOUT_CYCLES`=16 -> sel/enable drop, `rsp_valid`=1 with `rsp_err`=1 17 cycles after MODE_ACCESS entry; next request accepted normally.
- Back-to-back tx baud 5 then tx baud 5 with cache macro defined -> second request skips addr-4 write, `rsp_valid` at k+6; without macro both at k+9.
- `rst` pulsed during DATA_ACCESS -> outputs 0 and `req_ready`=1 immediately, no `rsp_valid`; baud 0 request afterward writes wdata=1 at addr 4.

Source files
------------

// File: rtl/uart_apb_sequencer.sv
// ---------------------------------------------------------------------------
// uart_apb_sequencer
//
// Bus-master sequencer for one uart_binary instance. A single valid/ready
// request becomes the write sequence baud divisor (addr 4) -> T/R mode
// (addr 2) -> data (addr 0). Each write uses a one-cycle setup phase and an
// access phase held until uart_ready. Consecutive writes are separated by a
// one-cycle idle gap. An access phase that waits longer than TIMEOUT_CYCLES
// is aborted and reported with rsp_err.
//
// Optional feature (macro UART_SEQ_BAUD_CACHE_EN):
//   The last successfully written baud divisor is remembered. A request
//   whose effective divisor matches it skips the baud write.
//
// Parameters:
//   TIMEOUT_CYCLES - max cycles an access phase may wait for uart_ready (>=2)
//
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready, req_dir, req_baud, req_data - request handshake
//   rsp_valid, rsp_data, rsp_err                      - completion
//   uart_sel, uart_enable, uart_addr, uart_wdata      - UART bus outputs
//   uart_rdata, uart_ready                            - UART bus inputs
// ---------------------------------------------------------------------------
module uart_apb_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dir,
  input  logic [15:0] req_baud,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        uart_sel,
  output logic        uart_enable,
  output logic [9:0]  uart_addr,
  output logic [31:0] uart_wdata,
  input  logic [31:0] uart_rdata,
  input  logic        uart_ready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_BAUD_SETUP  = 4'd1;
  localparam logic [3:0] S_BAUD_ACCESS = 4'd2;
  localparam logic [3:0] S_GAP1        = 4'd3;
  localparam logic [3:0] S_MODE_SETUP  = 4'd4;
  localparam logic [3:0] S_MODE_ACCESS = 4'd5;
  localparam logic [3:0] S_GAP2        = 4'd6;
  localparam logic [3:0] S_DATA_SETUP  = 4'd7;
  localparam logic [3:0] S_DATA_ACCESS = 4'd8;
  localparam logic [3:0] S_DONE        = 4'd9;

  logic [3:0]       state;
  logic             dir_q;
  logic [15:0]      baud_q;   // effective divisor (0 already mapped to 1)
  logic [7:0]       data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      baud_eff;
  logic             baud_hit;
  logic             timed_out;
  logic             unused_rdata_hi;

  assign unused_rdata_hi = ^uart_rdata[31:8];
  assign baud_eff        = (req_baud == 16'd0) ? 16'd1 : req_baud;
  assign timed_out       = (cnt_q == CNT_MAX);

`ifdef UART_SEQ_BAUD_CACHE_EN
  logic        cache_vld;
  logic [15:0] cache_baud;
  assign baud_hit = cache_vld && (cache_baud == baud_eff);
`else
  assign baud_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      dir_q    <= 1'b0;
      baud_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
`ifdef UART_SEQ_BAUD_CACHE_EN
      cache_vld  <= 1'b0;
      cache_baud <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            dir_q    <= req_dir;
            baud_q   <= baud_eff;
            data_q   <= req_data;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            state    <= baud_hit ? S_MODE_SETUP : S_BAUD_SETUP;
          end
        end
        S_BAUD_SETUP: begin
          cnt_q <= '0;
          state <= S_BAUD_ACCESS;
        end
        S_MODE_SETUP: begin
          cnt_q <= '0;
          state <= S_MODE_ACCESS;
        end
        S_DATA_SETUP: begin
          cnt_q <= '0;
          state <= S_DATA_ACCESS;
        end
        S_BAUD_ACCESS, S_MODE_ACCESS, S_DATA_ACCESS: begin
          // ready wins over an expiring counter on the same cycle
          if (uart_ready) begin
            case (state)
              S_BAUD_ACCESS: begin
                state <= S_GAP1;
`ifdef UART_SEQ_BAUD_CACHE_EN
                cache_vld  <= 1'b1;
                cache_baud <= baud_q;
`endif
              end
              S_MODE_ACCESS: state <= S_GAP2;
              default: begin
                rsp_data <= dir_q ? uart_rdata[7:0] : 8'h00;
                state    <= S_DONE;
              end
            endcase
          end else if (timed_out) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
            state    <= S_DONE;
`ifdef UART_SEQ_BAUD_CACHE_EN
            if (state == S_BAUD_ACCESS) cache_vld <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP1:  state <= S_MODE_SETUP;
        S_GAP2:  state <= S_DATA_SETUP;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decode from the registered state so reset drops them at once.
  always_comb begin
    uart_sel    = 1'b0;
    uart_enable = 1'b0;
    uart_addr   = '0;
    uart_wdata  = '0;
    case (state)
      S_BAUD_SETUP, S_BAUD_ACCESS: begin
        uart_sel    = 1'b1;
        uart_enable = (state == S_BAUD_ACCESS);
        uart_addr   = 10'd4;
        uart_wdata  = {16'h0000, baud_q};
      end
      S_MODE_SETUP, S_MODE_ACCESS: begin
        uart_sel    = 1'b1;
        uart_enable = (state == S_MODE_ACCESS);
        uart_addr   = 10'd2;
        uart_wdata  = dir_q ? 32'd2 : 32'd1;
      end
      S_DATA_SETUP, S_DATA_ACCESS: begin
        uart_sel    = 1'b1;
        uart_enable = (state == S_DATA_ACCESS);
        uart_addr   = 10'd0;
        uart_wdata  = dir_q ? 32'd0 : {24'h000000, data_q};
      end
      default: ;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);

endmodule
